// File: rtl/banco_registradores.sv
// rtl/banco_registradores.sv - multi-port register bank with byte strobes, bypass and clear sweep
// One strobed write port, two registered read ports, optional hardwired zero register.
module banco_registradores #(
  parameter int DATA_W   = 64,
  parameter int ADDR_W   = 5,
  parameter int ZERO_REG = 1,
  parameter int BYPASS   = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                we,
  input  logic [ADDR_W-1:0]   ads_w,
  input  logic [DATA_W/8-1:0] wstrb,
  input  logic [DATA_W-1:0]   din,
  input  logic [ADDR_W-1:0]   ads_a,
  input  logic [ADDR_W-1:0]   ads_b,
  output logic [DATA_W-1:0]   dout_a,
  output logic [DATA_W-1:0]   dout_b,
  input  logic                clr,
  output logic                busy
);

  localparam int NREGS  = 2**ADDR_W;
  localparam int NBYTES = DATA_W/8;

  typedef enum logic {IDLE, SWEEP} state_t;

  state_t              state_q;
  logic [ADDR_W-1:0]   idx_q;
  logic                busy_q;
  logic [DATA_W-1:0]   regs_q [NREGS];
  logic [DATA_W-1:0]   dout_a_q, dout_b_q;
  logic [DATA_W-1:0]   dout_a_d, dout_b_d;
  logic [DATA_W-1:0]   mask_d, wdata_d;
  logic                wr_en;

  // Merged word: untouched bytes keep the old contents, strobed bytes take din.
  always_comb begin
    mask_d = '0;
    for (int i = 0; i < NBYTES; i++) begin
      mask_d[8*i +: 8] = {8{wstrb[i]}};
    end
    wdata_d = (regs_q[ads_w] & ~mask_d) | (din & mask_d);
  end

  assign wr_en = we && !busy_q && !((ZERO_REG != 0) && (ads_w == '0));

  always_comb begin
    dout_a_d = regs_q[ads_a];
    dout_b_d = regs_q[ads_b];
    if ((BYPASS != 0) && wr_en && (ads_a == ads_w)) dout_a_d = wdata_d;
    if ((BYPASS != 0) && wr_en && (ads_b == ads_w)) dout_b_d = wdata_d;
    if ((ZERO_REG != 0) && (ads_a == '0)) dout_a_d = '0;
    if ((ZERO_REG != 0) && (ads_b == '0)) dout_b_d = '0;
    if (busy_q) begin
      dout_a_d = '0;
      dout_b_d = '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      busy_q   <= 1'b0;
      dout_a_q <= '0;
      dout_b_q <= '0;
      for (int i = 0; i < NREGS; i++) begin
        regs_q[i] <= '0;
      end
    end else begin
      dout_a_q <= dout_a_d;
      dout_b_q <= dout_b_d;
      if (wr_en) regs_q[ads_w] <= wdata_d;
      case (state_q)
        IDLE: begin
          if (clr) begin
            state_q <= SWEEP;
            busy_q  <= 1'b1;
            idx_q   <= '0;
          end
        end
        SWEEP: begin
          // Writes are blocked while sweeping, so this is the only store to the bank.
          regs_q[idx_q] <= '0;
          idx_q         <= idx_q + ADDR_W'(1);
          if (idx_q == '1) begin
            state_q <= IDLE;
            busy_q  <= 1'b0;
          end
        end
        default: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
      endcase
    end
  end

  assign dout_a = dout_a_q;
  assign dout_b = dout_b_q;
  assign busy   = busy_q;

endmodule

// File: doc/banco_registradores.md
# banco_registradores

Parametrised multi-port register bank for the datapath: one write port with byte strobes, two independent registered read ports, write-to-read bypass and an optional hardwired-zero register 0. Reads and writes may occur in the same cycle. A sequential clear engine zeroes the whole bank on request without a reset. Replaces the single-port 64×32 memory as the architectural register file feeding the ALU operand path.

## Interface

**Parameters**

- `DATA_W`, default 64: word width; must be a multiple of 8.
- `ADDR_W`, default 5: address width; `NREGS = 2**ADDR_W`.
- `ZERO_REG`, default 1: when 1, register 0 always reads 0 and writes to it are discarded.
- `BYPASS`, default 1: when 1, a same-cycle write to the read address is forwarded to the read output.

**Ports**

- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `we` in 1: write enable.
- `ads_w` in ADDR_W: write address.
- `wstrb` in DATA_W/8: byte write strobes; bit i covers `din[8i+7:8i]`.
- `din` in DATA_W: write data.
- `ads_a` in ADDR_W: read address, port A.
- `ads_b` in ADDR_W: read address, port B.
- `dout_a` out DATA_W: registered read data, port A.
- `dout_b` out DATA_W: registered read data, port B.
- `clr` in 1: clear request (single-cycle pulse).
- `busy` out 1: clear sweep in progress.

## Operation

- **Storage:** NREGS × DATA_W flops, with no RAM inference.
- **Write:**
  - On an edge with `we=1` and `busy=0`, `reg[ads_w]` becomes `(old & ~M) | (din & M)`. M is the byte mask expanded from `wstrb`.
  - `wstrb=0` performs no change.
  - With `ZERO_REG=1` and `ads_w=0`, the write is discarded.
- **Read:**
  - Every edge, both ports update unconditionally: `dout_a <= reg[ads_a]` and `dout_b <= reg[ads_b]`.
  - A read does not depend on `we`; both ports may address the same register.
- **Zero register:** with `ZERO_REG=1`, a read of address 0 returns 0 regardless of bypass.
- **Bypass:**
  - Applies when `BYPASS=1`, `we=1`, `busy=0`, and `ads_x==ads_w` (x = a or b).
  - That port captures the merged write value rather than the stale value.
  - With `BYPASS=0`, the port captures the old value; the new value appears on the next read.
- **Clear FSM:**
  - States: IDLE and SWEEP. A counter `idx` of ADDR_W bits.
  - IDLE → SWEEP on `clr=1`; `idx` is set to 0.
  - In SWEEP, each edge zeroes `reg[idx]` and increments `idx`.
  - SWEEP → IDLE on the edge that zeroes `reg[NREGS-1]`; `idx` wraps to 0.
  - `clr` while in SWEEP is ignored; there is no restart.
  - During SWEEP:
    - writes are dropped silently; no error flag is raised;
    - `dout_a` and `dout_b` capture 0.
- **Simultaneous `clr` and `we` in IDLE:** the write is performed on that edge and is then zeroed by the sweep.
- **Reset:** `rst_n=0` asynchronously forces all registers to 0, `dout_a=dout_b=0`, `busy=0`, state IDLE and `idx=0`. Reset asserted mid-sweep aborts the sweep; the bank is zero anyway.
- **Widths:** no arithmetic except `idx` increment, which wraps modulo NREGS. Addresses are always in range because `NREGS=2**ADDR_W`.

## Timing

- **Read latency:** 1 cycle. The address presented before edge N appears on `dout` after edge N.
- **Write visibility:**
  - `BYPASS=1`: data written at edge N is visible on `dout` after edge N when the same address is read in that cycle.
  - `BYPASS=0`: visible after edge N+1.
- **Clear:**
  - `clr` sampled at edge N gives `busy=1` after edge N.
  - `busy` stays high for NREGS cycles and falls after edge N+NREGS.
  - The first write accepted is at edge N+NREGS+1.
- **Outputs driven by flops:** `busy`, `dout_a` and `dout_b` only. There is no combinational input-to-output path.
- **Reset release:** the first functional edge is the first rising `clk` after `rst_n` goes high. Reset recovery is met externally.

## Test plan

1. **Reset:** assert `rst_n=0` mid-run, then release. All of `dout_a`, `dout_b` and `busy` read 0 immediately, and reading addresses 0..31 returns 0.
2. **Byte-strobe write:**
   - Write `reg[16]=64'h0123456789ABCDEF` with `wstrb=8'hFF`.
   - Then write `din=64'hFFFF_FFFF_FFFF_FFFF` with `wstrb=8'h0F`.
   - Reading address 16 returns `64'h01234567FFFFFFFF`.
3. **Bypass and dual read:**
   - Write `reg[5]=45` while `ads_a=5` and `ads_b=5`: both outputs show 45 on the next cycle.
   - Repeat with `BYPASS=0`: both outputs show the old value, then 45 one cycle later.
4. **Zero register:** write `64'hDEAD` to address 0 with `ZERO_REG=1` → a read of address 0 returns 0. With `ZERO_REG=0` → the read returns `64'hDEAD`.
5. **Clear sweep:**
   - Fill all registers with nonzero data, pulse `clr`.
   - `busy` is high for exactly 32 cycles and outputs read 0 throughout.
   - A write to address 3 during the sweep is dropped.
   - A second `clr` during the sweep is ignored.
   - After `busy` falls, every address reads 0.
6. **Simultaneous and interrupted clear:**
   - `clr` and a write to address 31 on the same edge → address 31 reads 0 after the sweep.
   - `rst_n` pulsed at sweep cycle 10 → `busy=0` immediately and the state is IDLE.
